// File: rtl/cam_pkg.sv
// Shared constants for the OV7670 capture path.
// FSM state codes, RGB565 field slices and RGB444 field widths.
package cam_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;

  localparam int c_nb_buf_red   = 4;
  localparam int c_nb_buf_green = 4;
  localparam int c_nb_buf_blue  = 4;

  // Top bits of each RGB565 field in the 16-bit pixel {hi,lo}.
  localparam int c_r_hi = 15;
  localparam int c_r_lo = 16 - c_nb_buf_red;
  localparam int c_g_hi = 10;
  localparam int c_g_lo = 11 - c_nb_buf_green;
  localparam int c_b_hi = 4;
  localparam int c_b_lo = 5 - c_nb_buf_blue;

  function automatic logic [3:0] px_red(input logic [15:0] px);
    return px[c_r_hi:c_r_lo];
  endfunction

  function automatic logic [3:0] px_green(input logic [15:0] px);
    return px[c_g_hi:c_g_lo];
  endfunction

  function automatic logic [3:0] px_blue(input logic [15:0] px);
    return px[c_b_hi:c_b_lo];
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer, parameterized width.
// All bits share the same latency so a bundle stays aligned.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  // Two register stages, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 RGB565 capture into a 12-bit RGB444 frame buffer.
// Define OV_CAPTURE_SWAP_RB_EN to emit {B,G,R} instead of {R,G,B}.
module ov7670_capture
  import cam_pkg::*;
#(
  parameter int c_img_cols    = 160,
  parameter int c_img_rows    = 120,
  parameter int c_img_pxls    = c_img_cols * c_img_rows,
  parameter int c_nb_img_pxls = 15,
  parameter int c_nb_buf      = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cam_pclk,
  input  logic                     cam_vsync,
  input  logic                     cam_href,
  input  logic [7:0]               cam_data,
  input  logic                     capture_en,
  output logic                     we,
  output logic [c_nb_img_pxls-1:0] addr,
  output logic [c_nb_buf-1:0]      data,
  output logic                     frame_done,
  output logic                     overflow,
  output logic                     busy
);

  localparam int AW = c_nb_img_pxls;
  localparam logic [AW-1:0] LAST = AW'(c_img_pxls - 1);

  logic [10:0] raw;
  logic [10:0] syn;
  logic [10:0] cur_q;
  logic [10:0] prev_q;

  assign raw = {cam_pclk, cam_vsync, cam_href, cam_data};

  sync_2ff #(.W(11)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (raw),
    .q_o (syn)
  );

  // Sample register plus previous sample for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q  <= '0;
      prev_q <= '0;
    end else begin
      cur_q  <= syn;
      prev_q <= cur_q;
    end
  end

  logic       pclk_rise;
  logic       vs_cur;
  logic       vs_rise;
  logic       vs_fall;
  logic       hr_cur;
  logic       hr_fall;
  logic [7:0] dat;

  assign pclk_rise = cur_q[10] & ~prev_q[10];
  assign vs_cur    = cur_q[9];
  assign vs_rise   = cur_q[9] & ~prev_q[9];
  assign vs_fall   = ~cur_q[9] & prev_q[9];
  assign hr_cur    = cur_q[8];
  assign hr_fall   = ~cur_q[8] & prev_q[8];
  assign dat       = cur_q[7:0];

  logic [1:0]          state_q, state_d;
  logic                phase_q, phase_d;
  logic [7:0]          hi_q, hi_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic                full_q, full_d;
  logic                we_q, we_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [c_nb_buf-1:0] data_q, data_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;

  logic [15:0] px;
  logic [11:0] pk;

  assign px = {hi_q, dat};

`ifdef OV_CAPTURE_SWAP_RB_EN
  assign pk = {px_blue(px), px_green(px), px_red(px)};
`else
  assign pk = {px_red(px), px_green(px), px_blue(px)};
`endif

  // Capture FSM, byte assembler and address counter.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    full_d  = full_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (vs_cur) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (vs_fall && capture_en) begin
          state_d = S_ACTIVE;
          cnt_d   = '0;
          addr_d  = '0;
          full_d  = 1'b0;
          phase_d = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      S_ACTIVE: begin
        if (vs_rise) begin
          done_d  = 1'b1;
          phase_d = 1'b0;
          state_d = S_WAIT;
        end else if (hr_fall) begin
          phase_d = 1'b0;
        end else if (pclk_rise && hr_cur) begin
          phase_d = ~phase_q;
          if (!phase_q) begin
            hi_d = dat;
          end else if (full_q) begin
            ovf_d = 1'b1;
          end else begin
            we_d   = 1'b1;
            addr_d = cnt_q;
            data_d = c_nb_buf'(pk);
            if (cnt_q == LAST) full_d = 1'b1;
            else cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      phase_q <= 1'b0;
      hi_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign we         = we_q;
  assign addr       = addr_q;
  assign data       = data_q;
  assign frame_done = done_q;
  assign overflow   = ovf_q;
  assign busy       = (state_q == S_ACTIVE);

endmodule

// File: tb/tb_ov7670_capture.sv
// Bench for ov7670_capture on a reduced 8x4 frame.
// Camera model drives frames; a monitor checks writes from a queue.
`timescale 1ns/1ps
module tb_ov7670_capture;

  localparam int COLS = 8;
  localparam int ROWS = 4;
  localparam int PXLS = COLS * ROWS;
  localparam int AW   = 15;

`ifdef OV_CAPTURE_SWAP_RB_EN
  localparam logic [11:0] EXP_F800 = 12'h00F;
`else
  localparam logic [11:0] EXP_F800 = 12'hF00;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cam_pclk = 1'b0;
  logic          cam_vsync = 1'b0;
  logic          cam_href = 1'b0;
  logic [7:0]    cam_data = 8'h00;
  logic          capture_en = 1'b0;
  logic          we;
  logic [AW-1:0] addr;
  logic [11:0]   data;
  logic          frame_done;
  logic          overflow;
  logic          busy;

  always #5 clk = ~clk;

  ov7670_capture #(
    .c_img_cols (COLS),
    .c_img_rows (ROWS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cam_pclk   (cam_pclk),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_data   (cam_data),
    .capture_en (capture_en),
    .we         (we),
    .addr       (addr),
    .data       (data),
    .frame_done (frame_done),
    .overflow   (overflow),
    .busy       (busy)
  );

  int checks = 0;
  int fails  = 0;
  int done_cnt = 0;
  time t_lo = 0;
  time t_vs = 0;
  bit prev_we = 1'b0;
  logic [AW+11:0] exp_q[$];

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Monitor: pops an expected {addr,data} for every write strobe.
  always @(negedge clk) begin
    logic [AW+11:0] e;
    if (we) begin
      chk("we_gap", prev_we, 0);
      chk("wr_latency", $time - t_lo, 40);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {addr, data}, 0);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr_data", {addr, data}, e);
      end
    end
    if (frame_done) begin
      done_cnt++;
      chk("done_latency", $time - t_vs, 40);
    end
    prev_we = we;
  end

  task automatic send_byte(input logic [7:0] b, input bit lo);
    @(negedge clk);
    cam_pclk = 1'b0;
    cam_data = b;
    @(negedge clk);
    @(negedge clk);
    cam_pclk = 1'b1;
    if (lo) t_lo = $time;
    @(negedge clk);
  endtask

  task automatic do_reset();
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_outputs",
        {we, addr, data, frame_done, overflow, busy}, 0);
    rst = 1'b0;
  endtask

  task automatic frame(input int rows_n, input int bpl,
                       input logic [7:0] hi, input logic [7:0] lo,
                       input logic [11:0] exp_d, input bit en_s,
                       input bit en_m, input int rst_pix);
    int pix;
    bit cap;
    @(negedge clk);
    cam_vsync = 1'b1;
    t_vs = $time;
    repeat (12) @(negedge clk);
    capture_en = en_s;
    cam_vsync = 1'b0;
    repeat (8) @(negedge clk);
    pix = 0;
    cap = en_s;
    for (int r = 0; r < rows_n; r++) begin
      if (r == rows_n / 2) capture_en = en_m;
      @(negedge clk);
      cam_href = 1'b1;
      for (int b = 0; b < bpl; b++) begin
        if (b % 2 == 0 && pix == rst_pix && cap) begin
          do_reset();
          cap = 1'b0;
        end
        send_byte((b % 2) ? lo : hi, b % 2);
        if (b % 2 == 1) begin
          if (cap && pix < PXLS)
            exp_q.push_back({AW'(pix), exp_d});
          pix++;
        end
      end
      @(negedge clk);
      cam_href = 1'b0;
      cam_pclk = 1'b0;
      repeat (8) @(negedge clk);
    end
    @(negedge clk);
    cam_vsync = 1'b1;
    t_vs = $time;
    repeat (10) @(negedge clk);
  endtask

  task automatic end_chk(input string nm, input int done_base,
                         input int done_inc, input bit ovf,
                         input bit do_addr, input int exp_addr);
    chk({nm, "_queue_left"}, exp_q.size(), 0);
    chk({nm, "_frame_done"}, done_cnt - done_base, done_inc);
    chk({nm, "_overflow"}, overflow, ovf);
    chk({nm, "_busy"}, busy, 0);
    if (do_addr) chk({nm, "_last_addr"}, addr, exp_addr);
    exp_q.delete();
  endtask

  initial begin
    int base;
    repeat (4) @(negedge clk);
    chk("reset_outputs",
        {we, addr, data, frame_done, overflow, busy}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    base = done_cnt;
    frame(ROWS, 2 * COLS, 8'hF8, 8'h1F, 12'hF0F, 1, 1, -1);
    end_chk("full", base, 1, 0, 1, PXLS - 1);

    base = done_cnt;
    frame(ROWS, 2 * COLS, 8'hF8, 8'h1F, 12'hF0F, 0, 1, -1);
    end_chk("gated", base, 0, 0, 1, PXLS - 1);

    base = done_cnt;
    frame(ROWS, 2 * COLS, 8'h07, 8'hE0, 12'h0F0, 1, 0, -1);
    end_chk("en_drop", base, 1, 0, 1, PXLS - 1);
    capture_en = 1'b1;

    base = done_cnt;
    frame(ROWS + 1, 2 * COLS, 8'hF8, 8'h1F, 12'hF0F, 1, 1, -1);
    end_chk("ovf", base, 1, 1, 1, PXLS - 1);

    base = done_cnt;
    frame(ROWS, 2 * COLS, 8'hF8, 8'h00, EXP_F800, 1, 1, -1);
    end_chk("pack", base, 1, 0, 1, PXLS - 1);

    base = done_cnt;
    frame(ROWS, 2 * COLS + 1, 8'h07, 8'hE0, 12'h0F0, 1, 1, -1);
    end_chk("odd", base, 1, 0, 1, PXLS - 1);

    base = done_cnt;
    frame(ROWS, 2 * COLS, 8'hF8, 8'h1F, 12'hF0F, 1, 1, 13);
    end_chk("rst_mid", base, 0, 0, 0, 0);

    base = done_cnt;
    frame(ROWS, 2 * COLS, 8'h07, 8'hE0, 12'h0F0, 1, 1, -1);
    end_chk("after_rst", base, 1, 0, 1, PXLS - 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
